// File: rtl/barrel_shift_pkg.sv
// Shared shift-mode encodings for the pipelined barrel shifter.
// Optional flag outputs are enabled with the BARREL_SHIFT_FLAGS_EN macro.
package barrel_shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } shift_op_t;

endpackage

// File: rtl/barrel_shift_stage.sv
// One barrel-shifter mux level: conditional shift by DIST, fill logic and stage register.
// Carry/zero flag tracking is compiled in with BARREL_SHIFT_FLAGS_EN.
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic [AW-1:0]    up_amt,
    input  logic [1:0]       up_op,
`ifdef BARREL_SHIFT_FLAGS_EN
    input  logic             up_carry,
    output logic             dn_carry,
    output logic             dn_zero,
`endif
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data,
    output logic [AW-1:0]    dn_amt,
    output logic [1:0]       dn_op
);

    localparam int K = $clog2(DIST);

    shift_op_t        op;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] next_data;

    assign op = shift_op_t'(up_op);

    always_comb begin
        // NOTE: default assignment first so every path drives the signal; no latch is inferred.
        shifted = up_data;
        case (op)
            OP_SLL:  shifted = up_data << DIST;
            OP_SRL:  shifted = up_data >> DIST;
            OP_SRA:  shifted = {{DIST{up_data[WIDTH-1]}}, up_data[WIDTH-1:DIST]};
            OP_ROL:  shifted = {up_data[WIDTH-DIST-1:0], up_data[WIDTH-1:WIDTH-DIST]};
            default: shifted = up_data;
        endcase
        next_data = up_amt[K] ? shifted : up_data;
    end

`ifdef BARREL_SHIFT_FLAGS_EN
    // The last stage that actually shifts supplies the final carry; later stages pass it on.
    logic out_bit;
    logic next_carry;

    always_comb begin
        out_bit = 1'b0;
        case (op)
            OP_SLL:         out_bit = up_data[WIDTH-DIST];
            OP_SRL, OP_SRA: out_bit = up_data[DIST-1];
            OP_ROL:         out_bit = shifted[0];
            default:        out_bit = 1'b0;
        endcase
        next_carry = up_amt[K] ? out_bit : up_carry;
    end
`endif

    assign up_ready = ~dn_valid | dn_ready;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath registers are reset too so out_data reads 0 right after reset.
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_amt   <= '0;
            dn_op    <= '0;
`ifdef BARREL_SHIFT_FLAGS_EN
            dn_carry <= 1'b0;
            dn_zero  <= 1'b0;
`endif
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data  <= next_data;
                dn_amt   <= up_amt;
                dn_op    <= up_op;
`ifdef BARREL_SHIFT_FLAGS_EN
                dn_carry <= next_carry;
                dn_zero  <= (next_data == '0);
`endif
            end
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined WIDTH-bit barrel shifter (SLL/SRL/SRA/ROL), one register stage per mux level.
// Define BARREL_SHIFT_FLAGS_EN to add out_carry/out_zero outputs.
module barrel_shift_pipe
    import barrel_shift_pkg::*;
#(
    parameter int  WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_op,
`ifdef BARREL_SHIFT_FLAGS_EN
    output logic             out_carry,
    output logic             out_zero,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Index k is the input of stage k; index SHW is the pipe output.
    logic             valid_w [SHW+1];
    logic             ready_w [SHW+1];
    logic [WIDTH-1:0] data_w  [SHW+1];
    logic [SHW-1:0]   amt_w   [SHW+1];
    logic [1:0]       op_w    [SHW+1];
`ifdef BARREL_SHIFT_FLAGS_EN
    logic             carry_w [SHW+1];
    logic             zero_w  [SHW];
`endif

    assign valid_w[0]   = in_valid;
    assign data_w[0]    = in_data;
    assign amt_w[0]     = in_amt;
    assign op_w[0]      = in_op;
    assign ready_w[SHW] = out_ready;
    assign in_ready     = ready_w[0];
    assign out_valid    = valid_w[SHW];
    assign out_data     = data_w[SHW];
`ifdef BARREL_SHIFT_FLAGS_EN
    assign carry_w[0]   = 1'b0;
    assign out_carry    = carry_w[SHW];
    assign out_zero     = zero_w[SHW-1];
`endif

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k),
            .AW    (SHW)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (valid_w[k]),
            .up_ready (ready_w[k]),
            .up_data  (data_w[k]),
            .up_amt   (amt_w[k]),
            .up_op    (op_w[k]),
`ifdef BARREL_SHIFT_FLAGS_EN
            .up_carry (carry_w[k]),
            .dn_carry (carry_w[k+1]),
            .dn_zero  (zero_w[k]),
`endif
            .dn_valid (valid_w[k+1]),
            .dn_ready (ready_w[k+1]),
            .dn_data  (data_w[k+1]),
            .dn_amt   (amt_w[k+1]),
            .dn_op    (op_w[k+1])
        );
    end

    // The final stage's amt/op copies have no consumer.
    logic unused_tail;
    assign unused_tail = ^{amt_w[SHW], op_w[SHW]};

endmodule
